progmem_bus_arbiter: RTL and testbench
======================================

// Module: progmem_bus_arbiter
// PURPOSE
//  Two-master arbiter sharing one PicoRV32-style valid/ready memory slave
//  (program memory). M0 = CPU fetch/load port, M1 = loader/debug port.
//  Grants one master at a time, holds the grant until the slave's ready,
//  then inserts a one-cycle idle gap so a registered slave ready can drop.
// PARAMETERS
//  RR_EN_DEFAULT   1             1 = round-robin, 0 = fixed priority (M0 wins)
//  TIMEOUT_CYCLES  64            watchdog limit in cycles (ARB_TIMEOUT_EN only)
//  ERR_DATA        32'hDEAD_BEEF rdata returned on timeout (ARB_TIMEOUT_EN only)
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  rstn      in   1   asynchronous active-low reset
//  m0_valid  in   1   M0 request
//  m0_addr   in   32  M0 byte address
//  m0_ready  out  1   M0 transfer complete
//  m0_rdata  out  32  M0 read data, valid while m0_ready=1
//  m1_valid  in   1   M1 request
//  m1_addr   in   32  M1 byte address
//  m1_ready  out  1   M1 transfer complete
//  m1_rdata  out  32  M1 read data, valid while m1_ready=1
//  s_valid   out  1   request to slave
//  s_addr    out  32  address to slave, muxed from granted master
//  s_ready   in   1   slave completion
//  s_rdata   in   32  slave read data
//  grant     out  2   one-hot current owner {M1,M0}; 2'b00 = none
//  err       out  1   sticky timeout flag (0 when ARB_TIMEOUT_EN undefined)
// BEHAVIOUR
//  - Reset: state=IDLE, grant=00, s_valid=0, m*_ready=0, err=0, watchdog=0,
//    last-owner pointer=M1 (so M0 wins the first tie).
//  - States: IDLE, OWN0, OWN1, GAP.
//  - IDLE/GAP: arbitrate on m*_valid; winner registered -> OWNx next cycle.
//    Only one valid: that master. Both valid: RR -> master != last owner;
//    fixed -> M0. None: IDLE.
//  - GAP always lasts exactly one cycle with s_valid=0; arbitration sampled
//    in GAP lands OWNx on the following cycle (no back-to-back s_valid).
//  - OWNx: s_valid = mx_valid, s_addr = mx_addr (combinational mux).
//    mx_ready = s_ready & mx_valid (combinational); other master's ready=0.
//    mx_rdata = s_rdata; non-owner rdata = 0.
//    On s_ready & mx_valid: last owner <= x, next state GAP.
//    mx_valid drops before s_ready (abort): no ready, next state GAP.
//  - s_ready while IDLE/GAP is ignored; never forwarded to any master.
//  - Latency, single master, 1-cycle slave: valid@T0, grant@T1 (s_valid),
//    ready@T2, GAP@T3, next grant@T4.
//  - Address not modified; slave decodes its own window.
//  - rstn low mid-transfer: immediate return to reset values, no ready.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: watchdog counts cycles in OWNx, cleared on entry.
//   Reaching TIMEOUT_CYCLES-1 without s_ready: mx_ready=1 for one cycle with
//   mx_rdata=ERR_DATA, err <= 1 (sticky until reset), next state GAP.
//  ARB_TIMEOUT_EN undefined: no counter; OWNx waits indefinitely; err tied 0.
// TESTING
//  1. M0 valid, addr 0x0010_0004, slave ready 1 cycle later -> grant=01 @T1,
//     m0_ready=1 @T2 with s_rdata, GAP @T3, m1_ready never asserted.
//  2. M0 and M1 valid same cycle from reset, RR -> M0 served first, M1
//     granted 2 cycles after M0 ready; repeat -> order alternates M0,M1,M0,M1.
//  3. Both held valid, fixed priority -> M0 served every 4 cycles, M1 starves.
//  4. M1 drops valid while OWN1 before s_ready -> no m1_ready, GAP, IDLE;
//     s_ready pulse during GAP -> no ready to either master.
//  5. rstn low while OWN0 -> grant=00, s_valid=0, m0_ready=0 immediately.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ready -> m0_ready after
//     8 cycles in OWN0, m0_rdata=32'hDEAD_BEEF, err=1 until reset.

Source files
------------

// File: rtl/progmem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | progmem_bus_arbiter: two-master valid/ready arbiter in front of one program |
// | memory slave; optional watchdog enabled by ARB_TIMEOUT_EN.   Rev 1.0        |
// +----------------------------------------------------------------------------+
module progmem_bus_arbiter #(
  parameter bit          RR_EN_DEFAULT  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_m1;
  logic   w_any_valid;
  logic   w_pick_m1;
  logic   w_owner_valid;
  logic   w_timeout;

  generate
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("progmem_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  // The last-owner pointer starts at M1 so that M0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (m0_ready) begin
        r_last_m1 <= 1'b0;
      end else if (m1_ready) begin
        r_last_m1 <= 1'b1;
      end
    end
  end

  assign w_any_valid   = m0_valid | m1_valid;
  assign w_pick_m1     = m1_valid & (~m0_valid | (RR_EN_DEFAULT & ~r_last_m1));
  assign w_owner_valid = ((r_state == S_OWN0) & m0_valid) |
                         ((r_state == S_OWN1) & m1_valid);
  assign grant         = {r_state == S_OWN1, r_state == S_OWN0};

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned c_WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [c_WD_W-1:0] r_wd;
  logic              r_err;

  // Counter is zero on the first owned cycle because it is held clear outside OWNx.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == S_OWN0) || (r_state == S_OWN1)) begin
        r_wd <= r_wd + 1'b1;
      end else begin
        r_wd <= '0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_timeout = w_owner_valid & ~s_ready &
                     (r_wd == c_WD_W'(TIMEOUT_CYCLES - 1));
  assign err       = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    s_valid     = 1'b0;
    s_addr      = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_any_valid) begin
          w_state_nxt = w_pick_m1 ? S_OWN1 : S_OWN0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OWN0: begin
        s_valid = m0_valid;
        s_addr  = m0_addr;
        if (w_timeout) begin
          m0_ready    = 1'b1;
          m0_rdata    = ERR_DATA;
          w_state_nxt = S_GAP;
        end else begin
          m0_ready = s_ready & m0_valid;
          m0_rdata = s_rdata;
          // A dropped request aborts the transfer without completing it.
          if (!m0_valid || s_ready) begin
            w_state_nxt = S_GAP;
          end
        end
      end
      S_OWN1: begin
        s_valid = m1_valid;
        s_addr  = m1_addr;
        if (w_timeout) begin
          m1_ready    = 1'b1;
          m1_rdata    = ERR_DATA;
          w_state_nxt = S_GAP;
        end else begin
          m1_ready = s_ready & m1_valid;
          m1_rdata = s_rdata;
          if (!m1_valid || s_ready) begin
            w_state_nxt = S_GAP;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_progmem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_progmem_bus_arbiter: directed bench for round-robin and fixed-priority  |
// | arbiter instances with behavioural slaves.                     Rev 1.0     |
// +----------------------------------------------------------------------------+
module tb_progmem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr;

  logic        a_m0_ready, a_m1_ready, a_s_valid, a_s_ready, a_err;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_rdata;
  logic [1:0]  a_grant;
  logic        b_m0_ready, b_m1_ready, b_s_valid, b_s_ready, b_err;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_rdata;
  logic [1:0]  b_grant;

  logic        slv_auto;
  logic        slv_force;
  int          slv_wait;
  logic        a_rdy, b_rdy;
  logic [31:0] a_rd, b_rd;
  int          a_cnt, b_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] c_KEY = 32'h5A5A_0000;

  always #5 clk = ~clk;

  progmem_bus_arbiter #(
    .RR_EN_DEFAULT (1'b1),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .m0_valid(m0_valid),
    .m0_addr (m0_addr),
    .m0_ready(a_m0_ready),
    .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid),
    .m1_addr (m1_addr),
    .m1_ready(a_m1_ready),
    .m1_rdata(a_m1_rdata),
    .s_valid (a_s_valid),
    .s_addr  (a_s_addr),
    .s_ready (a_s_ready),
    .s_rdata (a_s_rdata),
    .grant   (a_grant),
    .err     (a_err)
  );

  progmem_bus_arbiter #(
    .RR_EN_DEFAULT (1'b0),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) u_fp (
    .clk     (clk),
    .rstn    (rstn),
    .m0_valid(m0_valid),
    .m0_addr (m0_addr),
    .m0_ready(b_m0_ready),
    .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid),
    .m1_addr (m1_addr),
    .m1_ready(b_m1_ready),
    .m1_rdata(b_m1_rdata),
    .s_valid (b_s_valid),
    .s_addr  (b_s_addr),
    .s_ready (b_s_ready),
    .s_rdata (b_s_rdata),
    .grant   (b_grant),
    .err     (b_err)
  );

  // Registered slaves: ready after slv_wait extra cycles of s_valid, data = addr ^ key.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rdy <= 1'b0; a_rd <= '0; a_cnt <= 0;
    end else begin
      a_rdy <= a_s_valid && !a_rdy && (a_cnt == slv_wait);
      a_cnt <= (a_s_valid && !a_rdy && (a_cnt != slv_wait)) ? a_cnt + 1 : 0;
      if (a_s_valid && !a_rdy) a_rd <= a_s_addr ^ c_KEY;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_rdy <= 1'b0; b_rd <= '0; b_cnt <= 0;
    end else begin
      b_rdy <= b_s_valid && !b_rdy && (b_cnt == slv_wait);
      b_cnt <= (b_s_valid && !b_rdy && (b_cnt != slv_wait)) ? b_cnt + 1 : 0;
      if (b_s_valid && !b_rdy) b_rd <= b_s_addr ^ c_KEY;
    end
  end

  assign a_s_ready = slv_auto ? a_rdy : slv_force;
  assign b_s_ready = slv_auto ? b_rdy : slv_force;
  assign a_s_rdata = a_rd;
  assign b_s_rdata = b_rd;

  // {grant[1:0], s_valid, m0_ready, m1_ready}
  wire [4:0] a_obs = {a_grant, a_s_valid, a_m0_ready, a_m1_ready};
  wire [4:0] b_obs = {b_grant, b_s_valid, b_m0_ready, b_m1_ready};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    m0_valid  = 1'b0;
    m1_valid  = 1'b0;
    slv_force = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1;
    m0_addr = 32'h10; m1_addr = 32'h20;
    slv_auto = 1'b0; slv_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (a_obs !== 5'b00000) begin
        n_fail++; $display("FAIL reset_rr_obs cyc%0d: got %b expected %b", i, a_obs, 5'b00000);
      end
      n_chk++;
      if (b_obs !== 5'b00000) begin
        n_fail++; $display("FAIL reset_fp_obs cyc%0d: got %b expected %b", i, b_obs, 5'b00000);
      end
      n_chk++;
      if ({a_m0_rdata, a_m1_rdata, a_s_addr} !== 96'h0 || a_err !== 1'b0) begin
        n_fail++; $display("FAIL reset_data: got rdata0=%h rdata1=%h saddr=%h err=%b expected all 0",
                           a_m0_rdata, a_m1_rdata, a_s_addr, a_err);
      end
      n_chk++;
      cyc();
    end
    slv_auto = 1'b1; slv_force = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    logic [4:0] ev [5] = '{5'b00000, 5'b01100, 5'b01110, 5'b00000, 5'b00000};
    logic       vv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    m0_addr = 32'h0010_0004;
    for (int i = 0; i < 5; i++) begin
      m0_valid = vv[i];
      #2;
      if (a_obs !== ev[i]) begin
        n_fail++; $display("FAIL single_obs T%0d: got %b expected %b", i, a_obs, ev[i]);
      end
      n_chk++;
      if (i == 1) begin
        if (a_s_addr !== 32'h0010_0004) begin
          n_fail++; $display("FAIL single_saddr: got %h expected %h", a_s_addr, 32'h0010_0004);
        end
        n_chk++;
      end
      if (i == 2) begin
        if (a_m0_rdata !== (32'h0010_0004 ^ c_KEY) || a_m1_rdata !== 32'h0) begin
          n_fail++; $display("FAIL single_rdata: got m0=%h m1=%h expected m0=%h m1=0",
                             a_m0_rdata, a_m1_rdata, 32'h0010_0004 ^ c_KEY);
        end
        n_chk++;
      end
      cyc();
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] ev [12] = '{5'b00000, 5'b01100, 5'b01110, 5'b00000, 5'b10100, 5'b10101,
                            5'b00000, 5'b01100, 5'b01110, 5'b00000, 5'b10100, 5'b10101};
    do_reset();
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (a_obs !== ev[i]) begin
        n_fail++; $display("FAIL rr_obs T%0d: got %b expected %b", i, a_obs, ev[i]);
      end
      n_chk++;
      if (i == 4) begin
        if (a_s_addr !== 32'h0000_0200) begin
          n_fail++; $display("FAIL rr_saddr_m1: got %h expected %h", a_s_addr, 32'h0000_0200);
        end
        n_chk++;
      end
      if (i == 5) begin
        if (a_m1_rdata !== (32'h0000_0200 ^ c_KEY) || a_m0_rdata !== 32'h0) begin
          n_fail++; $display("FAIL rr_rdata_m1: got m1=%h m0=%h expected m1=%h m0=0",
                             a_m1_rdata, a_m0_rdata, 32'h0000_0200 ^ c_KEY);
        end
        n_chk++;
      end
      cyc();
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic test_fixed_priority();
    logic [4:0] e;
    int         n0 = 0;
    int         n1 = 0;
    do_reset();
    slv_wait = 1;
    m0_addr = 32'h0000_0040; m1_addr = 32'h0000_0080;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      #2;
      if (i == 0) e = 5'b00000;
      else if (((i - 1) % 4) == 2) e = 5'b01110;
      else if (((i - 1) % 4) == 3) e = 5'b00000;
      else e = 5'b01100;
      if (b_obs !== e) begin
        n_fail++; $display("FAIL fixed_obs T%0d: got %b expected %b", i, b_obs, e);
      end
      n_chk++;
      if (b_m0_ready) n0++;
      if (b_m1_ready) n1++;
      cyc();
    end
    if (n0 !== 3 || n1 !== 0) begin
      n_fail++; $display("FAIL fixed_counts: got m0=%0d m1=%0d expected m0=3 m1=0", n0, n1);
    end
    n_chk++;
    m0_valid = 1'b0; m1_valid = 1'b0;
    slv_wait = 0;
  endtask

  task automatic test_abort();
    logic [4:0] ev [6] = '{5'b00000, 5'b10100, 5'b10000, 5'b00000, 5'b00000, 5'b01110};
    do_reset();
    slv_auto = 1'b0; slv_force = 1'b0;
    m1_addr = 32'h0000_0300; m0_addr = 32'h0000_0304;
    for (int i = 0; i < 6; i++) begin
      m1_valid  = (i < 2);
      slv_force = (i >= 3);
      m0_valid  = (i >= 4);
      #2;
      if (a_obs !== ev[i]) begin
        n_fail++; $display("FAIL abort_obs T%0d: got %b expected %b", i, a_obs, ev[i]);
      end
      n_chk++;
      if (i == 3) begin
        if (a_m0_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin
          n_fail++; $display("FAIL abort_gap_rdata: got m0=%h m1=%h expected 0", a_m0_rdata, a_m1_rdata);
        end
        n_chk++;
      end
      cyc();
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    slv_force = 1'b0; slv_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_addr = 32'h0000_0400; m0_valid = 1'b1;
    cyc();
    #2;
    if (a_obs !== 5'b01100) begin
      n_fail++; $display("FAIL midrst_own: got %b expected %b", a_obs, 5'b01100);
    end
    n_chk++;
    cyc();
    #2;
    if (a_obs !== 5'b01110) begin
      n_fail++; $display("FAIL midrst_ready: got %b expected %b", a_obs, 5'b01110);
    end
    n_chk++;
    rstn = 1'b0;
    #1;
    if (a_obs !== 5'b00000 || a_m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL midrst_async: got obs=%b rdata=%h expected obs=00000 rdata=0",
                         a_obs, a_m0_rdata);
    end
    n_chk++;
    do_reset();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [4:0] e;
    do_reset();
    slv_auto = 1'b0; slv_force = 1'b0;
    m0_addr = 32'h0000_0500;
    for (int i = 0; i < 11; i++) begin
      m0_valid = (i < 9);
      #2;
      if (i == 0 || i >= 9) e = 5'b00000;
      else if (i == 8) e = 5'b01110;
      else e = 5'b01100;
      if (a_obs !== e || a_err !== (i >= 9)) begin
        n_fail++; $display("FAIL timeout_obs T%0d: got obs=%b err=%b expected obs=%b err=%b",
                           i, a_obs, a_err, e, (i >= 9));
      end
      n_chk++;
      if (i == 8) begin
        if (a_m0_rdata !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL timeout_rdata: got %h expected %h", a_m0_rdata, 32'hDEAD_BEEF);
        end
        n_chk++;
      end
      cyc();
    end
    do_reset();
    #2;
    if (a_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_err_clear: got %b expected 0", a_err);
    end
    n_chk++;
    slv_auto = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    logic [4:0] e;
    do_reset();
    slv_auto = 1'b0; slv_force = 1'b0;
    m0_addr = 32'h0000_0600; m0_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #2;
      e = (i == 0) ? 5'b00000 : 5'b01100;
      if (a_obs !== e || a_err !== 1'b0) begin
        n_fail++; $display("FAIL wait_forever T%0d: got obs=%b err=%b expected obs=%b err=0",
                           i, a_obs, a_err, e);
      end
      n_chk++;
      cyc();
    end
    m0_valid = 1'b0;
    slv_auto = 1'b1;
  endtask
`endif

  initial begin
    rstn = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr = '0; m1_addr = '0;
    slv_auto = 1'b1; slv_force = 1'b0; slv_wait = 0;
    cyc();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_abort();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
